ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
Two-requester arbiter sharing the single-port word RAM (clk, addr[15:0], read, write[3:0], DATA_IN, DATA_OUT) between instruction fetch (port 0, read-only) and load/store (port 1, read/write). It sits between the core and the RAM.
- Issues at most one RAM access per cycle.
- Returns read data one cycle after grant, matching the RAM's 1-cycle read latency.
- Fixed priority with a starvation guard by default; round-robin optional.

Parameters:
ADDR_W, 16, RAM address width (word address)
DATA_W, 32, data width; byte-strobe width is DATA_W/8
STARVE_MAX, 4, consecutive cycles port 0 may wait before it is force-granted (fixed-priority mode); must be >=1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
m0_req  in  1  port 0 read request; held with stable m0_addr until granted
m0_addr  in  ADDR_W  port 0 read address
m0_gnt  out  1  port 0 granted this cycle (combinational)
m0_rvalid  out  1  port 0 read data valid (registered)
m0_rdata  out  DATA_W  port 0 read data
m1_req  in  1  port 1 request; held stable until granted
m1_addr  in  ADDR_W  port 1 address
m1_we  in  DATA_W/8  byte write strobes; 0 = read
m1_wdata  in  DATA_W  port 1 write data
m1_gnt  out  1  port 1 granted this cycle (combinational)
m1_rvalid  out  1  port 1 read data valid (registered); never set for writes
m1_rdata  out  DATA_W  port 1 read data
ram_addr  out  ADDR_W  to RAM addr
ram_read  out  1  to RAM read
ram_write  out  DATA_W/8  to RAM write strobes
ram_din  out  DATA_W  to RAM DATA_IN
ram_dout  in  DATA_W  from RAM DATA_OUT

Behaviour:
- Reset, asynchronous while rst=1: m0_gnt=m1_gnt=0, ram_read=0, ram_write=0, ram_addr=0, ram_din=0, m0_rvalid=m1_rvalid=0, m0_rdata=m1_rdata=0, wait_cnt=0, last_gnt=1 (port 0 wins the first RR tie).
- Grant rule: gnt is combinational from req and state. A transfer occurs on a rising edge where req&gnt=1. Exactly one or zero ports are granted per cycle.
- Fixed priority (default): port 1 wins a tie unless wait_cnt==STARVE_MAX, in which case port 0 wins.
- wait_cnt (saturating):
  - increments each cycle m0_req&!m0_gnt;
  - clears on m0 grant or when m0_req=0.
- RAM drive on a grant:
  - ram_addr = granted address.
  - Port 0 grant: ram_read=1, ram_write=0.
  - Port 1 grant with m1_we==0: ram_read=1, ram_write=0.
  - Port 1 grant with m1_we!=0: ram_read=0, ram_write=m1_we, ram_din=m1_wdata.
- RAM drive with no grant: ram_read=0, ram_write=0, ram_addr=0, ram_din=0.
- Response pipeline: 1-entry tag register {valid, port} loaded on each read grant.
  - Next cycle: the matching mX_rvalid=1 and mX_rdata=ram_dout (pass-through), both outputs registered/driven for exactly one cycle.
  - Back-to-back reads every cycle are supported with full throughput.
  - The non-target rdata holds its previous value.
- Reset mid-operation: an outstanding read tag is discarded; no rvalid after rst deasserts.
- Requester dropping req before grant is legal; no access is issued.
- Write followed immediately by a read of the same address: ordering is by grant order; the RAM returns the written data.

Optional Feature:
Macro ARB_ROUND_ROBIN_EN.
- Defined: on a tie, grant the port not granted last; last_gnt updates on every grant; wait_cnt is held at 0 and STARVE_MAX is ignored.
- Undefined: fixed priority with the starvation guard, as above.

Test Plan:
1. Assert rst for 2 cycles with both reqs high -> all gnt, rvalid, ram_read and ram_write are 0; release -> first grant on the next cycle.
2. m0_req only, m0_addr=3, RAM word 3=0x00000013 -> m0_gnt=1, ram_read=1, ram_addr=3 that cycle; next cycle m0_rvalid=1, m0_rdata=0x00000013; m1_rvalid=0.
3. m1 write addr=5, we=4'b0011, wdata=0xDEADBEEF -> ram_write=4'b0011, ram_read=0, ram_din=0xDEADBEEF; no m1_rvalid. Then m1 read addr=5 -> m1_rdata low half=0xBEEF.
4. Fixed priority, STARVE_MAX=4, m1_req held high for 10 cycles, m0_req high -> m1 granted cycles 1-4, m0 granted cycle 5, then m1 resumes; wait_cnt returns to 0.
5. Port 0 read granted, rst pulsed in the following cycle -> m0_rvalid stays 0 and no stale rvalid after release.
6. ARB_ROUND_ROBIN_EN defined, both reqs held for 6 cycles -> grants alternate 0,1,0,1,0,1 with one rvalid per read the following cycle.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares a single-port word RAM (1-cycle read latency) between instruction
//   fetch (port 0, read-only) and load/store (port 1, read/write). At most one
//   RAM access is issued per cycle. Read data returns one cycle after grant.
//
//   Optional build macro: ARB_ROUND_ROBIN_EN
//     undefined : fixed priority (port 1 wins ties) with a starvation guard
//                 that force-grants port 0 after STARVE_MAX lost cycles.
//     defined   : ties go to the port not granted last.
//
//   Ports
//     clk, rst               clock (rising edge), async active-high reset
//     m0_req/addr            port 0 read request (held until granted)
//     m0_gnt                 port 0 grant (combinational)
//     m0_rvalid/rdata        port 0 read response
//     m1_req/addr/we/wdata   port 1 request; we==0 means read
//     m1_gnt                 port 1 grant (combinational)
//     m1_rvalid/rdata        port 1 read response (never for writes)
//     ram_addr/read/write/din  RAM drive
//     ram_dout               RAM read data
module ram_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W/8-1:0] m1_we,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_read,
  output logic [DATA_W/8-1:0] ram_write,
  output logic [DATA_W-1:0]   ram_din,
  input  logic [DATA_W-1:0]   ram_dout
);
  localparam int BE_W = DATA_W / 8;

  // pick0: on a tie, port 0 wins
  logic pick0;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = port 1 was granted last, so port 0 takes the first tie after reset
  logic last_gnt;

  assign pick0 = last_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_gnt <= 1'b1;
    else if (m0_gnt) last_gnt <= 1'b0;
    else if (m1_gnt) last_gnt <= 1'b1;
  end
`else
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] wait_cnt;

  assign pick0 = (wait_cnt == CNT_W'(STARVE_MAX));

  // counts consecutive cycles port 0 waits while requesting; saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= '0;
    else if (m0_req && !m0_gnt) begin
      if (wait_cnt != CNT_W'(STARVE_MAX)) wait_cnt <= wait_cnt + CNT_W'(1);
    end else wait_cnt <= '0;
  end
`endif

  // grants are masked during reset so nothing reaches the RAM
  assign m0_gnt = !rst && m0_req && (!m1_req || pick0);
  assign m1_gnt = !rst && m1_req && !m0_gnt;

  logic m1_is_wr;
  logic rd_gnt;
  assign m1_is_wr = (m1_we != '0);
  assign rd_gnt   = m0_gnt || (m1_gnt && !m1_is_wr);

  always_comb begin
    ram_addr  = '0;
    ram_read  = 1'b0;
    ram_write = '0;
    ram_din   = '0;
    if (m0_gnt) begin
      ram_addr = m0_addr;
      ram_read = 1'b1;
    end else if (m1_gnt) begin
      ram_addr = m1_addr;
      if (m1_is_wr) begin
        ram_write = m1_we;
        ram_din   = m1_wdata;
      end else begin
        ram_read = 1'b1;
      end
    end
  end

  // single-entry response tag: RAM data arrives the cycle after the grant
  logic tag_vld;
  logic tag_port;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld  <= 1'b0;
      tag_port <= 1'b0;
    end else begin
      tag_vld  <= rd_gnt;
      tag_port <= m1_gnt;
    end
  end

  assign m0_rvalid = tag_vld && !tag_port;
  assign m1_rvalid = tag_vld &&  tag_port;

  // rdata is ram_dout while valid; otherwise the last delivered word is held
  logic [DATA_W-1:0] hold0, hold1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      if (m0_rvalid) hold0 <= ram_dout;
      if (m1_rvalid) hold1 <= ram_dout;
    end
  end

  assign m0_rdata = m0_rvalid ? ram_dout : hold0;
  assign m1_rdata = m1_rvalid ? ram_dout : hold1;

  logic unused_be;
  assign unused_be = ^BE_W;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 1-cycle-latency RAM.
module tb_ram_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req;
  logic [15:0] m0_addr, m1_addr;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata, m1_wdata;
  logic [3:0]  m1_we;
  logic [15:0] ram_addr;
  logic        ram_read;
  logic [3:0]  ram_write;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_read(ram_read), .ram_write(ram_write),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // RAM model: contents reload on rst (word 3 = 0x13), 1-cycle read latency
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[3]   <= 32'h00000013;
      ram_dout <= 32'h0;
    end else begin
      if (ram_read) ram_dout <= mem[ram_addr[7:0]];
      for (int b = 0; b < 4; b++)
        if (ram_write[b]) mem[ram_addr[7:0]][b*8 +: 8] <= ram_din[b*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    m0_req = 0; m1_req = 0; m1_we = 0; m1_wdata = 0; m0_addr = 0; m1_addr = 0;
  endtask

  initial begin
    rst = 1; idle();
    m0_req = 1; m1_req = 1;
    // 1: reset with both requests high
    step(); step();
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_ram_read", ram_read, 0);
    chk("rst_ram_write", ram_write, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    rst = 0; #1;
    chk("rel_m1_gnt", m1_gnt, 1);
    chk("rel_m0_gnt", m0_gnt, 0);
    // requests withdrawn before the edge: no access issued
    idle(); #1;
    chk("drop_gnt", {m0_gnt, m1_gnt, ram_read}, 0);
    step();
    chk("drop_rvalid", {m0_rvalid, m1_rvalid}, 0);

    // 2: port 0 read of word 3
    m0_req = 1; m0_addr = 3; #1;
    chk("p0_gnt", m0_gnt, 1);
    chk("p0_ram_read", ram_read, 1);
    chk("p0_ram_addr", ram_addr, 3);
    step(); idle();
    chk("p0_rvalid", m0_rvalid, 1);
    chk("p0_rdata", m0_rdata, 32'h13);
    chk("p0_m1_rvalid", m1_rvalid, 0);
    #1;
    chk("idle_ram_addr", {ram_addr, ram_din}, 0);
    step();
    chk("p0_rvalid_1cyc", m0_rvalid, 0);
    chk("p0_rdata_hold", m0_rdata, 32'h13);

    // 3: partial write then read back
    m1_req = 1; m1_addr = 5; m1_we = 4'b0011; m1_wdata = 32'hDEADBEEF; #1;
    chk("wr_gnt", m1_gnt, 1);
    chk("wr_ram_write", ram_write, 4'b0011);
    chk("wr_ram_read", ram_read, 0);
    chk("wr_ram_din", ram_din, 32'hDEADBEEF);
    chk("wr_ram_addr", ram_addr, 5);
    // read of the same address issued the very next cycle
    step(); m1_we = 0; m1_wdata = 0; #1;
    chk("wr_no_rvalid", m1_rvalid, 0);
    chk("rd_ram_read", ram_read, 1);
    step(); idle();
    chk("rd_m1_rvalid", m1_rvalid, 1);
    chk("rd_m1_rdata", m1_rdata, 32'h0000BEEF);
    chk("rd_m0_hold", m0_rdata, 32'h13);
    step();

    // full-word write by port 1, then port 0 reads it back-to-back
    m1_req = 1; m1_addr = 7; m1_we = 4'hF; m1_wdata = 32'h12345678;
    step(); idle();
    m0_req = 1; m0_addr = 7; #1;
    chk("raw_m0_gnt", m0_gnt, 1);
    step(); idle();
    chk("raw_m0_rdata", m0_rdata, 32'h12345678);
    chk("raw_m1_hold", m1_rdata, 32'h0000BEEF);
    step();

    // 5: reset while a read is outstanding
    m0_req = 1; m0_addr = 3; #1;
    chk("rm_gnt", m0_gnt, 1);
    step(); idle();
    rst = 1; #1;
    chk("rm_rvalid_rst", m0_rvalid, 0);
    step(); rst = 0;
    for (int c = 0; c < 2; c++) begin
      chk("rm_no_stale", {m0_rvalid, m1_rvalid}, 0);
      step();
    end

    // 4 / 6: both ports contending from a fresh reset
    rst = 1; step(); rst = 0;
    m0_req = 1; m0_addr = 3; m1_req = 1; m1_addr = 5;
`ifdef ARB_ROUND_ROBIN_EN
    for (int c = 1; c <= 6; c++) begin
      logic e0;
      e0 = (c % 2) == 1;
`else
    for (int c = 1; c <= 10; c++) begin
      logic e0;
      e0 = (c == 5) || (c == 10);
`endif
      #1;
      chk($sformatf("arb_m0_gnt_c%0d", c), m0_gnt, e0);
      chk($sformatf("arb_m1_gnt_c%0d", c), m1_gnt, !e0);
      step();
      chk($sformatf("arb_m0_rvalid_c%0d", c), m0_rvalid, e0);
      chk($sformatf("arb_m1_rvalid_c%0d", c), m1_rvalid, !e0);
      if (e0) chk($sformatf("arb_m0_rdata_c%0d", c), m0_rdata, 32'h13);
    end
`ifndef ARB_ROUND_ROBIN_EN
    // guard cleared after the forced grant: port 1 wins the next tie
    #1;
    chk("arb_resume_m1", m1_gnt, 1);
`endif
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
